// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, latched operation codes
// and bus widths.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_BAD
  } op_t;

  // Asserting both read and write at once is a protocol error, not a priority choice.
  function automatic op_t decode_op(input logic rd, input logic wr);
    op_t op;
    if (rd && wr) begin
      op = OP_BAD;
    end else if (wr) begin
      op = OP_WR;
    end else begin
      op = OP_RD;
    end
    return op;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed RAM (DEPTH x DATA_W).
// Writes are synchronous and reads are combinational on the same word index.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the CPU data bus: one access per request, WAIT_CYCLES wait
// states, one-cycle DM_READY. Define DMEM_ALIGN_CHK_EN to flag misaligned addresses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int                DEPTH       = 1024,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DM_CS,
  input  logic              DM_R,
  input  logic              DM_W,
  input  logic [ADDR_W-1:0] DMEM_ADDR,
  input  logic [DATA_W-1:0] W_DATA,
  input  logic              ERR_CLR,
  output logic [DATA_W-1:0] R_DATA,
  output logic              DM_READY,
  output logic              ERR
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t             state, next_state;
  logic [3:0]         wait_cnt;
  logic [ADDR_W-1:0]  word_addr;
  logic               req_valid, req_oor, req_misalign, req_bad;
  op_t                req_op, lat_op, eff_op;
  logic [IDX_W-1:0]   req_idx, lat_idx, eff_idx;
  logic [DATA_W-1:0]  lat_wdata, eff_wdata, ram_rdata;
  logic               lat_bad, eff_bad;
  logic               commit, ram_we;

  // Whole-word offset from BASE_ADDR; any bit above the index field means out of range.
  assign word_addr = (DMEM_ADDR - BASE_ADDR) >> 2;
  assign req_idx   = word_addr[IDX_W-1:0];
  assign req_oor   = |word_addr[ADDR_W-1:IDX_W];
  assign req_op    = decode_op(DM_R, DM_W);
  assign req_valid = DM_CS && (DM_R || DM_W);

`ifdef DMEM_ALIGN_CHK_EN
  assign req_misalign = |DMEM_ADDR[1:0];
`else
  assign req_misalign = 1'b0;
`endif

  assign req_bad = (req_op == OP_BAD) || req_oor || req_misalign;

  // With no wait states the access commits on the accepting edge, straight from the bus.
  assign eff_op    = (state == IDLE) ? req_op  : lat_op;
  assign eff_idx   = (state == IDLE) ? req_idx : lat_idx;
  assign eff_wdata = (state == IDLE) ? W_DATA  : lat_wdata;
  assign eff_bad   = (state == IDLE) ? req_bad : lat_bad;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (wait_cnt == 4'd0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign commit   = (next_state == RESP);
  assign ram_we   = commit && !RST && (eff_op == OP_WR) && !eff_bad;
  assign DM_READY = (state == RESP);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= next_state;
      if (state == IDLE && req_valid) begin
        wait_cnt <= WAIT_LOAD;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Request capture; later bus changes are ignored until the access completes.
  always_ff @(posedge CLK) begin
    if (state == IDLE && req_valid) begin
      lat_op    <= req_op;
      lat_idx   <= req_idx;
      lat_wdata <= W_DATA;
      lat_bad   <= req_bad;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      R_DATA <= '0;
      ERR    <= 1'b0;
    end else begin
      if (commit && eff_bad) begin
        ERR <= 1'b1;
      end else if (ERR_CLR) begin
        ERR <= 1'b0;
      end
      // Writes leave R_DATA alone; failed reads and conflicting requests return zero.
      if (commit && eff_op != OP_WR) begin
        R_DATA <= eff_bad ? '0 : ram_rdata;
      end
    end
  end

  dmem_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (CLK),
    .we   (ram_we),
    .idx  (eff_idx),
    .wdata(eff_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: one zero-wait-state instance and
// one three-wait-state instance sharing clock and reset.
module tb_dmem_responder;
  import dmem_pkg::*;

`ifdef DMEM_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cs[2], rd[2], wr[2], errclr[2];
  logic [31:0] addr[2], wdata[2], rdata[2];
  logic        ready[2], err[2];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .CLK(clk), .RST(rst), .DM_CS(cs[0]), .DM_R(rd[0]), .DM_W(wr[0]),
    .DMEM_ADDR(addr[0]), .W_DATA(wdata[0]), .ERR_CLR(errclr[0]),
    .R_DATA(rdata[0]), .DM_READY(ready[0]), .ERR(err[0])
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) dut1 (
    .CLK(clk), .RST(rst), .DM_CS(cs[1]), .DM_R(rd[1]), .DM_W(wr[1]),
    .DMEM_ADDR(addr[1]), .W_DATA(wdata[1]), .ERR_CLR(errclr[1]),
    .R_DATA(rdata[1]), .DM_READY(ready[1]), .ERR(err[1])
  );

  // Drives one request from a falling edge and holds it until DM_READY; lat counts
  // falling edges to READY (0 = timed out). Optionally perturbs the bus mid-access.
  task automatic access(input int inst, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input bit disturb,
                        output int lat, output logic [31:0] rd_val,
                        output logic err_val, output logic ready_after);
    lat = 0; rd_val = '0; err_val = 1'b0;
    cs[inst] = 1'b1; rd[inst] = r; wr[inst] = w; addr[inst] = a; wdata[inst] = d;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready[inst]) begin
        lat = i; rd_val = rdata[inst]; err_val = err[inst];
        break;
      end
      if (disturb && i == 1) begin
        rd[inst] = ~r; wr[inst] = ~w; addr[inst] = a + 32'd4; wdata[inst] = 32'h5555_AAAA;
      end
    end
    cs[inst] = 1'b0; rd[inst] = 1'b0; wr[inst] = 1'b0;
    @(negedge clk);
    ready_after = ready[inst];
  endtask

  task automatic pulse_errclr(input int inst);
    errclr[inst] = 1'b1;
    @(negedge clk);
    errclr[inst] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tests++; if (ready[i] !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready%0d: got %b want 0", i, ready[i]); end
      tests++; if (rdata[i] !== 32'h0) begin fails++; $display("[TB] FAIL reset_rdata%0d: got %h want 0", i, rdata[i]); end
      tests++; if (err[i] !== 1'b0) begin fails++; $display("[TB] FAIL reset_err%0d: got %b want 0", i, err[i]); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_wait();
    int lat; logic [31:0] v; logic e, ra;
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, lat, v, e, ra);
    tests++; if (lat !== 1) begin fails++; $display("[TB] FAIL zw_wr_lat: got %0d want 1", lat); end
    tests++; if (ra !== 1'b0) begin fails++; $display("[TB] FAIL zw_wr_pulse: got %b want 0", ra); end
    tests++; if (e !== 1'b0) begin fails++; $display("[TB] FAIL zw_wr_err: got %b want 0", e); end
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, v, e, ra);
    tests++; if (lat !== 1) begin fails++; $display("[TB] FAIL zw_rd_lat: got %0d want 1", lat); end
    tests++; if (v !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL zw_rd_data: got %h want deadbeef", v); end
    tests++; if (ra !== 1'b0) begin fails++; $display("[TB] FAIL zw_rd_pulse: got %b want 0", ra); end
    access(0, 1'b0, 1'b1, 32'h14, 32'h1111_1111, 1'b0, lat, v, e, ra);
    tests++; if (v !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL zw_wr_keeps_rdata: got %h want deadbeef", v); end
    access(0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, lat, v, e, ra);
    tests++; if (v !== 32'h1111_1111) begin fails++; $display("[TB] FAIL zw_raw_data: got %h want 11111111", v); end
  endtask

  task automatic test_wait_states();
    int lat; logic [31:0] v; logic e, ra;
    access(1, 1'b0, 1'b1, 32'h20, 32'hA5A5_0001, 1'b0, lat, v, e, ra);
    tests++; if (lat !== 4) begin fails++; $display("[TB] FAIL ws_wr_lat: got %0d want 4", lat); end
    access(1, 1'b0, 1'b1, 32'h24, 32'h0000_2424, 1'b0, lat, v, e, ra);
    access(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, lat, v, e, ra);
    tests++; if (lat !== 4) begin fails++; $display("[TB] FAIL ws_rd_lat: got %0d want 4", lat); end
    tests++; if (v !== 32'hA5A5_0001) begin fails++; $display("[TB] FAIL ws_rd_data: got %h want a5a50001", v); end
    tests++; if (ra !== 1'b0) begin fails++; $display("[TB] FAIL ws_rd_pulse: got %b want 0", ra); end
    access(1, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, lat, v, e, ra);
    tests++; if (v !== 32'h0000_2424) begin fails++; $display("[TB] FAIL ws_ignored_input: got %h want 00002424", v); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] v; logic e, ra;
    access(0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, lat, v, e, ra);
    tests++; if (lat !== 1) begin fails++; $display("[TB] FAIL oor_rd_lat: got %0d want 1", lat); end
    tests++; if (v !== 32'h0) begin fails++; $display("[TB] FAIL oor_rd_data: got %h want 0", v); end
    tests++; if (e !== 1'b1) begin fails++; $display("[TB] FAIL oor_rd_err: got %b want 1", e); end
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, v, e, ra);
    tests++; if (e !== 1'b1) begin fails++; $display("[TB] FAIL oor_err_sticky: got %b want 1", e); end
    pulse_errclr(0);
    tests++; if (err[0] !== 1'b0) begin fails++; $display("[TB] FAIL oor_errclr: got %b want 0", err[0]); end
    errclr[0] = 1'b1;
    access(0, 1'b0, 1'b1, 32'h110, 32'hBAD0_BAD0, 1'b0, lat, v, e, ra);
    errclr[0] = 1'b0;
    tests++; if (e !== 1'b1) begin fails++; $display("[TB] FAIL oor_set_wins: got %b want 1", e); end
    tests++; if (err[0] !== 1'b0) begin fails++; $display("[TB] FAIL oor_clr_after: got %b want 0", err[0]); end
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, v, e, ra);
    tests++; if (v !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL oor_wr_dropped: got %h want deadbeef", v); end
  endtask

  task automatic test_conflict();
    int lat; logic [31:0] v; logic e, ra;
    access(0, 1'b0, 1'b1, 32'h8, 32'h0808_0808, 1'b0, lat, v, e, ra);
    access(0, 1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF, 1'b0, lat, v, e, ra);
    tests++; if (lat !== 1) begin fails++; $display("[TB] FAIL cf_lat: got %0d want 1", lat); end
    tests++; if (v !== 32'h0) begin fails++; $display("[TB] FAIL cf_rdata: got %h want 0", v); end
    tests++; if (e !== 1'b1) begin fails++; $display("[TB] FAIL cf_err: got %b want 1", e); end
    pulse_errclr(0);
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, lat, v, e, ra);
    tests++; if (v !== 32'h0808_0808) begin fails++; $display("[TB] FAIL cf_ram_kept: got %h want 08080808", v); end
    tests++; if (e !== 1'b0) begin fails++; $display("[TB] FAIL cf_err_cleared: got %b want 0", e); end
  endtask

  task automatic test_alignment();
    int lat; logic [31:0] v; logic e, ra;
    logic [31:0] want;
    access(0, 1'b0, 1'b1, 32'h4, 32'h0404_0404, 1'b0, lat, v, e, ra);
    access(0, 1'b0, 1'b1, 32'h6, 32'h6666_6666, 1'b0, lat, v, e, ra);
    tests++; if (lat !== 1) begin fails++; $display("[TB] FAIL al_lat: got %0d want 1", lat); end
    tests++; if (e !== ALIGN) begin fails++; $display("[TB] FAIL al_err: got %b want %b", e, ALIGN); end
    pulse_errclr(0);
    want = ALIGN ? 32'h0404_0404 : 32'h6666_6666;
    access(0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, lat, v, e, ra);
    tests++; if (v !== want) begin fails++; $display("[TB] FAIL al_word4: got %h want %h", v, want); end
  endtask

  task automatic test_reset_mid_access();
    int lat; logic [31:0] v; logic e, ra;
    bit seen;
    access(1, 1'b0, 1'b1, 32'h30, 32'h3030_3030, 1'b0, lat, v, e, ra);
    cs[1] = 1'b1; rd[1] = 1'b0; wr[1] = 1'b1; addr[1] = 32'h30; wdata[1] = 32'hFFFF_0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++; if (ready[1] !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_ready: got %b want 0", ready[1]); end
    tests++; if (dut1.state !== IDLE) begin fails++; $display("[TB] FAIL rst_mid_state: got %0d want %0d", dut1.state, IDLE); end
    rst = 1'b0; cs[1] = 1'b0; wr[1] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready[1]) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_no_ready: got %b want 0", seen); end
    access(1, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, lat, v, e, ra);
    tests++; if (v !== 32'h3030_3030) begin fails++; $display("[TB] FAIL rst_mid_wr_dropped: got %h want 30303030", v); end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cs[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0; errclr[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0;
    end
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_out_of_range();
    test_conflict();
    test_alignment();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
